// File: rtl/vehicle_pkg.sv
// rtl/vehicle_pkg.sv - shared types, default constants and helpers for the vehicle plant model
//
// Purpose: door-state encoding, default parameter values and the gap clamp
// helper, shared by vehicle_plant_model and its testbench.
// Ports: none (package).

package vehicle_pkg;

  typedef enum logic [1:0] {
    DOOR_LOCKED    = 2'd0,
    DOOR_UNLOCKING = 2'd1,
    DOOR_OPEN      = 2'd2,
    DOOR_LOCKING   = 2'd3
  } door_state_e;

  localparam int         DEF_TICK_DIV    = 4;
  localparam int         DEF_ACCEL_STEP  = 2;
  localparam int         DEF_DECEL_STEP  = 4;
  localparam logic [7:0] DEF_MAX_SPEED   = 8'd200;
  localparam int         DEF_DIST_SHIFT  = 2;
  localparam int         DEF_DOOR_CYCLES = 3;

  localparam logic [6:0] DIST_RESET = 7'd127;

  // Clamp a signed 10-bit gap candidate into the 7-bit distance range 0..127.
  function automatic logic [6:0] clamp_gap(input logic signed [9:0] v);
    logic [6:0] r;
    if (v < 10'sd0) begin
      r = 7'd0;
    end else if (v > 10'sd127) begin
      r = 7'd127;
    end else begin
      r = v[6:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - free-running prescaler producing the plant update tick
//
// Purpose: counts 0..TICK_DIV-1 and wraps; tick is high while the count
// equals TICK_DIV-1, so the plant updates on the clock edge that wraps it.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset, clears the count
//   tick - high for one cycle out of every TICK_DIV

module tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (cnt_q == LAST) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/vehicle_plant_model.sv
// rtl/vehicle_plant_model.sv - discrete plant model of a following vehicle with doors
//
// Purpose: models car speed, gap to a leading vehicle, a sticky collision flag
// and a door lock state machine. Speed and gap update once per prescaler tick.
// Ports:
//   clk              - clock, rising edge
//   rst              - synchronous active-high reset
//   accelerate_car   - acceleration command
//   unlock_doors     - door unlock request
//   lead_speed[7:0]  - leading vehicle speed
//   load             - one-cycle strobe loading init_distance
//   init_distance[6:0] - distance captured on load
//   car_speed[7:0]   - registered speed
//   leading_distance[6:0] - registered gap
//   doors_open       - registered, high only in door state OPEN
//   collision        - registered sticky crash flag

module vehicle_plant_model
  import vehicle_pkg::*;
#(
  parameter int         TICK_DIV    = DEF_TICK_DIV,
  parameter int         ACCEL_STEP  = DEF_ACCEL_STEP,
  parameter int         DECEL_STEP  = DEF_DECEL_STEP,
  parameter logic [7:0] MAX_SPEED   = DEF_MAX_SPEED,
  parameter int         DIST_SHIFT  = DEF_DIST_SHIFT,
  parameter int         DOOR_CYCLES = DEF_DOOR_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       accelerate_car,
  input  logic       unlock_doors,
  input  logic [7:0] lead_speed,
  input  logic       load,
  input  logic [6:0] init_distance,
  output logic [7:0] car_speed,
  output logic [6:0] leading_distance,
  output logic       doors_open,
  output logic       collision
);

  localparam int DCW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [DCW-1:0] DOOR_LAST = DCW'(DOOR_CYCLES - 1);

  logic tick;

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  logic [7:0]     speed_q, speed_d;
  logic [6:0]     dist_q, dist_d;
  logic           coll_q, coll_d;
  logic           open_q, open_d;
  door_state_e    door_q, door_d;
  logic [DCW-1:0] door_cnt_q, door_cnt_d;

  // Speed candidates, both saturating.
  logic [8:0] accel_sum;
  logic [7:0] speed_up;
  logic [7:0] speed_down;

  always_comb begin
    accel_sum  = {1'b0, speed_q} + 9'(ACCEL_STEP);
    speed_up   = (accel_sum > {1'b0, MAX_SPEED}) ? MAX_SPEED : accel_sum[7:0];
    speed_down = ({1'b0, speed_q} >= 9'(DECEL_STEP)) ? (speed_q - 8'(DECEL_STEP)) : 8'd0;
  end

  // Gap step uses the speed before this tick's update.
  logic signed [8:0] rel_speed;
  logic signed [8:0] gap_step;
  logic signed [9:0] gap_sum;
  logic [6:0]        gap_next;

  always_comb begin
    rel_speed = $signed({1'b0, lead_speed}) - $signed({1'b0, speed_q});
    gap_step  = rel_speed >>> DIST_SHIFT;
    gap_sum   = $signed({3'b000, dist_q}) + $signed({gap_step[8], gap_step});
    gap_next  = clamp_gap(gap_sum);
  end

  // Speed: a crash pins the car at rest; otherwise it only moves on a tick.
  always_comb begin
    speed_d = speed_q;
    if (coll_q) begin
      speed_d = 8'd0;
    end else if (tick) begin
      if (accelerate_car && (door_q == DOOR_LOCKED)) begin
        speed_d = speed_up;
      end else begin
        speed_d = speed_down;
      end
    end
  end

  // Distance and collision: load beats the tick's distance update.
  always_comb begin
    dist_d = dist_q;
    coll_d = coll_q;
    if (load) begin
      dist_d = init_distance;
      coll_d = 1'b0;
    end else if (tick && !coll_q) begin
      dist_d = gap_next;
      if (gap_next == 7'd0) begin
        coll_d = 1'b1;
      end
    end
  end

  // Door FSM: the counter runs only in the two transition states.
  always_comb begin
    door_d     = door_q;
    door_cnt_d = door_cnt_q;
    unique case (door_q)
      DOOR_LOCKED: begin
        if (unlock_doors && (speed_q == 8'd0)) begin
          door_d     = DOOR_UNLOCKING;
          door_cnt_d = '0;
        end
      end
      DOOR_UNLOCKING: begin
        if (door_cnt_q == DOOR_LAST) begin
          door_d     = DOOR_OPEN;
          door_cnt_d = '0;
        end else begin
          door_cnt_d = door_cnt_q + DCW'(1);
        end
      end
      DOOR_OPEN: begin
        if (!unlock_doors) begin
          door_d     = DOOR_LOCKING;
          door_cnt_d = '0;
        end
      end
      DOOR_LOCKING: begin
        if (door_cnt_q == DOOR_LAST) begin
          door_d     = DOOR_LOCKED;
          door_cnt_d = '0;
        end else begin
          door_cnt_d = door_cnt_q + DCW'(1);
        end
      end
      default: begin
        door_d     = DOOR_LOCKED;
        door_cnt_d = '0;
      end
    endcase
    open_d = (door_d == DOOR_OPEN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      speed_q    <= 8'd0;
      dist_q     <= DIST_RESET;
      coll_q     <= 1'b0;
      open_q     <= 1'b0;
      door_q     <= DOOR_LOCKED;
      door_cnt_q <= '0;
    end else begin
      speed_q    <= speed_d;
      dist_q     <= dist_d;
      coll_q     <= coll_d;
      open_q     <= open_d;
      door_q     <= door_d;
      door_cnt_q <= door_cnt_d;
    end
  end

  assign car_speed        = speed_q;
  assign leading_distance = dist_q;
  assign doors_open       = open_q;
  assign collision        = coll_q;

endmodule

// File: tb/tb_vehicle_plant_model.sv
// tb/tb_vehicle_plant_model.sv - directed self-checking bench for vehicle_plant_model
//
// Purpose: applies hand-computed directed vectors with default parameters.
// Ports: none (top-level bench).

module tb_vehicle_plant_model;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       accelerate_car = 1'b0;
  logic       unlock_doors = 1'b0;
  logic [7:0] lead_speed = 8'd0;
  logic       load = 1'b0;
  logic [6:0] init_distance = 7'd0;
  logic [7:0] car_speed;
  logic [6:0] leading_distance;
  logic       doors_open;
  logic       collision;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  vehicle_plant_model dut (
    .clk             (clk),
    .rst             (rst),
    .accelerate_car  (accelerate_car),
    .unlock_doors    (unlock_doors),
    .lead_speed      (lead_speed),
    .load            (load),
    .init_distance   (init_distance),
    .car_speed       (car_speed),
    .leading_distance(leading_distance),
    .doors_open      (doors_open),
    .collision       (collision)
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    accelerate_car = 1'b0;
    unlock_doors = 1'b0;
    load = 1'b0;
    cyc(1);
    rst = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_speed"}, car_speed, 8'd0);
    check({tag, "_dist"}, {1'b0, leading_distance}, 8'd127);
    check({tag, "_doors"}, {7'd0, doors_open}, 8'd0);
    check({tag, "_coll"}, {7'd0, collision}, 8'd0);
  endtask

  initial begin
    logic [7:0] max_seen;

    // Reset state
    cyc(1);
    check_reset_values("reset");

    // Acceleration toward saturation
    do_reset();
    accelerate_car = 1'b1;
    lead_speed = 8'd200;
    cyc(3);
    check("accel_before_tick", car_speed, 8'd0);
    cyc(1);
    check("accel_first_tick", car_speed, 8'd2);
    max_seen = car_speed;
    for (int i = 0; i < 395; i++) begin
      cyc(1);
      if (car_speed > max_seen) max_seen = car_speed;
    end
    check("accel_cycle_399", car_speed, 8'd198);
    cyc(1);
    check("accel_cycle_400", car_speed, 8'd200);
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      if (car_speed > max_seen) max_seen = car_speed;
    end
    check("accel_hold_sat", car_speed, 8'd200);
    check("accel_max_seen", max_seen, 8'd200);
    check("accel_dist", {1'b0, leading_distance}, 8'd127);

    // Deceleration without underflow
    do_reset();
    accelerate_car = 1'b1;
    lead_speed = 8'd200;
    cyc(12);
    check("decel_start", car_speed, 8'd6);
    accelerate_car = 1'b0;
    cyc(4);
    check("decel_tick1", car_speed, 8'd2);
    cyc(4);
    check("decel_tick2", car_speed, 8'd0);
    cyc(4);
    check("decel_tick3", car_speed, 8'd0);

    // Collision, sticky hold, load clears, upper clamp, load vs tick
    do_reset();
    accelerate_car = 1'b1;
    lead_speed = 8'd200;
    cyc(80);
    check("coll_speed40", car_speed, 8'd40);
    accelerate_car = 1'b0;
    lead_speed = 8'd0;
    load = 1'b1;
    init_distance = 7'd10;
    cyc(1);
    load = 1'b0;
    check("coll_loaded", {1'b0, leading_distance}, 8'd10);
    check("coll_load_keeps_speed", car_speed, 8'd40);
    cyc(3);
    check("coll_dist0", {1'b0, leading_distance}, 8'd0);
    check("coll_flag", {7'd0, collision}, 8'd1);
    check("coll_tick_speed", car_speed, 8'd36);
    cyc(1);
    check("coll_forced_stop", car_speed, 8'd0);
    lead_speed = 8'd255;
    cyc(3);
    check("coll_dist_hold", {1'b0, leading_distance}, 8'd0);
    check("coll_sticky", {7'd0, collision}, 8'd1);
    load = 1'b1;
    init_distance = 7'd120;
    cyc(1);
    load = 1'b0;
    check("load_clears_coll", {7'd0, collision}, 8'd0);
    check("load_120", {1'b0, leading_distance}, 8'd120);
    cyc(3);
    check("clamp_127", {1'b0, leading_distance}, 8'd127);
    cyc(3);
    load = 1'b1;
    init_distance = 7'd30;
    accelerate_car = 1'b1;
    cyc(1);
    load = 1'b0;
    check("load_tick_dist", {1'b0, leading_distance}, 8'd30);
    check("load_tick_speed", car_speed, 8'd2);
    cyc(4);
    check("gap_plus63", {1'b0, leading_distance}, 8'd93);
    check("gap_speed4", car_speed, 8'd4);

    // Door sequencing
    do_reset();
    accelerate_car = 1'b1;
    lead_speed = 8'd200;
    cyc(8);
    check("door_speed4", car_speed, 8'd4);
    accelerate_car = 1'b0;
    unlock_doors = 1'b1;
    cyc(3);
    check("door_ignored_moving", {7'd0, doors_open}, 8'd0);
    cyc(1);
    check("door_stopped", car_speed, 8'd0);
    check("door_still_locked", {7'd0, doors_open}, 8'd0);
    cyc(3);
    check("door_unlocking", {7'd0, doors_open}, 8'd0);
    cyc(1);
    check("door_open", {7'd0, doors_open}, 8'd1);
    accelerate_car = 1'b1;
    cyc(2);
    check("door_open_hold", {7'd0, doors_open}, 8'd1);
    unlock_doors = 1'b0;
    cyc(1);
    check("door_locking", {7'd0, doors_open}, 8'd0);
    cyc(1);
    check("door_accel_ignored", car_speed, 8'd0);
    cyc(4);
    check("door_locked_accel", car_speed, 8'd2);

    // Reset mid-UNLOCKING
    do_reset();
    unlock_doors = 1'b1;
    cyc(2);
    rst = 1'b1;
    accelerate_car = 1'b1;
    lead_speed = 8'd200;
    cyc(1);
    rst = 1'b0;
    unlock_doors = 1'b0;
    check_reset_values("rst_unlocking");
    cyc(3);
    check("rst_prescale_clear", car_speed, 8'd0);
    check("rst_door_aborted", {7'd0, doors_open}, 8'd0);
    cyc(1);
    check("rst_prescale_tick", car_speed, 8'd2);

    // Reset during collision
    do_reset();
    lead_speed = 8'd0;
    load = 1'b1;
    init_distance = 7'd0;
    cyc(1);
    load = 1'b0;
    cyc(3);
    check("rstcoll_flag", {7'd0, collision}, 8'd1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check_reset_values("rst_collision");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
